// File: rtl/funnel_pkg.sv
`default_nettype none
// ============================================================================
// funnel_pkg : shared helpers and encodings for the buffered funnel arbiter
// Rev 1.0
// ============================================================================
package funnel_pkg;

  localparam int c_prio_rr    = 0;
  localparam int c_prio_fixed = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // A tag is always at least one bit wide so the output bus never collapses.
  function automatic int tag_width(input int n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/funnel_chan_fifo.sv
`default_nettype none
// ============================================================================
// funnel_chan_fifo : per-channel circular FIFO, ready derived from count only
// Rev 1.0
// ============================================================================
module funnel_chan_fifo
  import funnel_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_not_full,
  output logic             o_not_empty
);

  localparam int              c_aw   = clog2(DEPTH);
  localparam logic [c_aw:0]   c_full = (c_aw + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wptr;
  logic [c_aw-1:0]  r_rptr;
  logic [c_aw:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_not_full  = (r_count != c_full);
  assign o_not_empty = (r_count != '0);
  assign o_rd_data   = r_mem[r_rptr];
  assign w_wr        = i_wr_en && o_not_full;
  assign w_rd        = i_rd_en && o_not_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_wr) r_mem[r_wptr] <= i_wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/funnel_arb_buffered.sv
`default_nettype none
// ============================================================================
// funnel_arb_buffered : N buffered channels funnelled into one tagged stream
// Rev 1.0
// ============================================================================
module funnel_arb_buffered
    import funnel_pkg::*;
#(
    parameter int funnelWidth  = 4,
    parameter int width        = 32,
    parameter int depth        = 4,
    parameter int priorityMode = 0
) (
    input  logic                                    CLK,
    input  logic                                    RST,
    input  logic [funnelWidth-1:0]                  in_enq__ENA,
    input  logic [funnelWidth*width-1:0]            in_enq_v,
    output logic [funnelWidth-1:0]                  in_enq__RDY,
    output logic                                    out_enq__ENA,
    output logic [tag_width(funnelWidth)+width-1:0] out_enq_v,
    input  logic                                    out_enq__RDY,
    output logic                                    idle
);

    localparam int                c_tw   = tag_width(funnelWidth);
    localparam logic [c_tw-1:0]   c_last = c_tw'(funnelWidth - 1);

    logic [width-1:0]       w_rd_data [funnelWidth];
    logic [funnelWidth-1:0] w_nonempty;
    logic [funnelWidth-1:0] w_deq;
    logic                   w_load;
    logic                   w_grant_valid;
    logic [c_tw-1:0]        w_grant_idx;
    int                     w_scan_idx;

    logic                   r_out_valid;
    logic [c_tw-1:0]        r_out_tag;
    logic [width-1:0]       r_out_data;
    logic [c_tw-1:0]        r_rr_ptr;

    for (genvar i = 0; i < funnelWidth; i++) begin : g_chan
        funnel_chan_fifo #(
            .WIDTH (width),
            .DEPTH (depth)
        ) u_fifo (
            .clk         (CLK),
            .rst         (RST),
            .i_wr_en     (in_enq__ENA[i]),
            .i_wr_data   (in_enq_v[i*width +: width]),
            .i_rd_en     (w_deq[i]),
            .o_rd_data   (w_rd_data[i]),
            .o_not_full  (in_enq__RDY[i]),
            .o_not_empty (w_nonempty[i])
        );
        assign w_deq[i] = w_load && w_grant_valid && (w_grant_idx == c_tw'(i));
    end

    assign out_enq__ENA = r_out_valid && out_enq__RDY;
    assign w_load       = !r_out_valid || out_enq__ENA;
    assign out_enq_v    = {r_out_tag, r_out_data};
    assign idle         = !r_out_valid && (w_nonempty == '0);

    // Scanning downward lets the lowest search offset win without a break.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_scan_idx    = 0;
        if (priorityMode == c_prio_fixed) begin
            for (int i = funnelWidth - 1; i >= 0; i--) begin
                if (w_nonempty[i]) begin
                    w_grant_valid = 1'b1;
                    w_grant_idx   = c_tw'(i);
                end
            end
        end else begin
            for (int k = funnelWidth - 1; k >= 0; k--) begin
                w_scan_idx = int'(r_rr_ptr) + k;
                if (w_scan_idx >= funnelWidth) w_scan_idx = w_scan_idx - funnelWidth;
                if (w_nonempty[w_scan_idx]) begin
                    w_grant_valid = 1'b1;
                    w_grant_idx   = c_tw'(w_scan_idx);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_out_data  <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load) begin
            r_out_valid <= w_grant_valid;
            if (w_grant_valid) begin
                r_out_tag  <= w_grant_idx;
                r_out_data <= w_rd_data[w_grant_idx];
                if (priorityMode == c_prio_rr) begin
                    r_rr_ptr <= (w_grant_idx == c_last) ? '0 : w_grant_idx + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
